// File: rtl/spi_flash_reader.sv
// SPI mode-0 flash read engine: one request streams req_len bytes (0 = 256) from req_addr; build with SPI_FLASH_FAST_READ_EN for 0x0B fast read plus 8 dummy clocks.
// Latency: flash_csb falls the cycle after handshake; each byte is valid the cycle after its 8th SCK rise.
// Backpressure: SCK is parked low before a byte's first rise while the previous byte is unaccepted.
module spi_flash_reader #(
    parameter int CLK_DIV  = 2,
    parameter int CSB_IDLE = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
    localparam bit         FAST   = 1'b1;
`else
    localparam logic [7:0] OPCODE = 8'h03;
    localparam bit         FAST   = 1'b0;
`endif
    localparam int GW = (CSB_IDLE > 1) ? $clog2(CSB_IDLE) : 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, STALL, GAP} state_t;

    state_t          state;
    logic [7:0]      div_cnt;
    logic [4:0]      bit_cnt;
    logic [31:0]     tx_sr;
    logic [6:0]      rx_sr;
    logic [8:0]      bytes_left;
    logic [GW-1:0]   gap_cnt;
    logic            tick;
    logic            shifting;

    assign tick      = (div_cnt == 8'(CLK_DIV - 1));
    assign shifting  = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 5'd0;
            tx_sr      <= 32'd0;
            rx_sr      <= 7'd0;
            bytes_left <= 9'd0;
            gap_cnt    <= '0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            flash_csb  <= 1'b1;
            flash_clk  <= 1'b0;
            flash_io0  <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (shifting)
                div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;

            case (state)
                IDLE: if (req_valid) begin
                    state      <= CMD;
                    flash_csb  <= 1'b0;
                    tx_sr      <= {OPCODE, req_addr};
                    flash_io0  <= OPCODE[7];
                    bytes_left <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                    bit_cnt    <= 5'd0;
                    div_cnt    <= 8'd0;
                end
                CMD, ADDR, DUMMY: if (tick) begin
                    flash_clk <= ~flash_clk;
                    if (flash_clk) begin
                        // Falling edge: advance the outgoing bit while SCK is going low.
                        bit_cnt   <= bit_cnt + 5'd1;
                        tx_sr     <= {tx_sr[30:0], 1'b0};
                        flash_io0 <= tx_sr[30];
                        if (state == CMD && bit_cnt == 5'd7)
                            state <= ADDR;
                        if (state == ADDR && bit_cnt == 5'd31) begin
                            bit_cnt   <= 5'd0;
                            flash_io0 <= 1'b0;
                            state     <= FAST ? DUMMY : DATA;
                        end
                        if (state == DUMMY) begin
                            flash_io0 <= 1'b0;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                state   <= DATA;
                            end
                        end
                    end
                end
                DATA: if (tick) begin
                    if (!flash_clk) begin
                        if (bit_cnt == 5'd0 && out_valid && !out_ready) begin
                            state   <= STALL;
                            div_cnt <= 8'd0;
                        end else begin
                            flash_clk <= 1'b1;
                            if (bit_cnt == 5'd7) begin
                                out_data   <= {rx_sr, flash_io1};
                                out_valid  <= 1'b1;
                                bit_cnt    <= 5'd0;
                                bytes_left <= bytes_left - 9'd1;
                            end else begin
                                rx_sr   <= {rx_sr[5:0], flash_io1};
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else begin
                        flash_clk <= 1'b0;
                        // Last byte shifted in: park until it is accepted before releasing CS.
                        if (bit_cnt == 5'd0 && bytes_left == 9'd0) begin
                            state   <= STALL;
                            div_cnt <= 8'd0;
                        end
                    end
                end
                STALL: if (!out_valid || out_ready) begin
                    if (bytes_left == 9'd0) begin
                        state     <= GAP;
                        flash_csb <= 1'b1;
                        gap_cnt   <= GW'(CSB_IDLE - 1);
                    end else begin
                        // Resume with the deferred first rise of the next byte.
                        state     <= DATA;
                        flash_clk <= 1'b1;
                        rx_sr     <= {rx_sr[5:0], flash_io1};
                        bit_cnt   <= 5'd1;
                        div_cnt   <= 8'd0;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clock cycles per SCK half-period; legal range 1..255.
REQ-002 SHALL have parameter CSB_IDLE, default 4: minimum clock cycles flash_csb stays high between transactions; minimum 1.
REQ-003 SHALL have the following ports:
  clock  in  1  sole clock; all flops on rising edge
  resetb  in  1  asynchronous active-low reset
  req_valid  in  1  read request valid
  req_ready  out  1  request accepted when req_valid && req_ready
  req_addr  in  24  flash byte address of first byte
  req_len  in  8  byte count; 0 = 256 bytes
  out_valid  out  1  out_data valid
  out_ready  in  1  consumer accepts byte
  out_data  out  8  read byte
  busy  out  1  transaction in progress
  flash_csb  out  1  chip select, active low
  flash_clk  out  1  SCK, SPI mode 0
  flash_io0  out  1  MOSI
  flash_io1  in  1  MISO

Function
REQ-004 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, STALL, GAP.
REQ-005 req_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of IDLE.
REQ-006 On handshake, SHALL latch req_addr/req_len, drive flash_csb low next cycle, and enter CMD.
REQ-007 SHALL shift MSB-first: 8-bit opcode in CMD, 24-bit address in ADDR, then bytes in DATA.
REQ-008 SHALL change flash_io0 only while flash_clk is low, and SHALL sample flash_io1 on the clock cycle in which flash_clk rises.
REQ-009 Each SCK half-period SHALL last exactly CLK_DIV clock cycles; flash_clk SHALL idle low.
REQ-010 After the 8th sampled bit of a byte, SHALL present it on out_data with out_valid=1 one cycle later and hold both stable until out_ready.
REQ-011 If the previous byte is still unaccepted at the point the next byte's first SCK rise is due, SHALL enter STALL with flash_clk held low and resume after acceptance; no bit SHALL be lost or duplicated.
REQ-012 After the last byte is accepted, SHALL raise flash_csb, enter GAP for CSB_IDLE cycles, then return to IDLE.
REQ-013 out_valid and out_ready high in the same cycle as a new byte completes SHALL accept the old byte and present the new one next cycle without gaps.
REQ-014 Byte count SHALL use a 9-bit counter so that req_len=0 reads exactly 256 bytes.
REQ-015 Address SHALL be sent as given; wrap past 0xFFFFFF is the flash's behaviour, not the block's.
REQ-016 req_valid while busy SHALL be ignored, not queued.

Reset
REQ-017 While resetb=0 SHALL asynchronously force: state IDLE, flash_csb=1, flash_clk=0, flash_io0=0, out_valid=0, out_data=0x00, busy=0, req_ready=1 (after release).
REQ-018 Reset mid-transaction SHALL drop the in-flight read; any partial byte SHALL be discarded.

Configuration
REQ-019 With SPI_FLASH_FAST_READ_EN defined: opcode 0x0B, DUMMY state of 8 SCK cycles (io0=0) between ADDR and DATA.
REQ-020 Without SPI_FLASH_FAST_READ_EN: opcode 0x03, DUMMY state skipped.

Verification
REQ-021 Bench SHALL use the team spiflash model, preloaded with byte[i] = i & 0xFF, and CLK_DIV=2 unless stated otherwise.
REQ-022 Single read: addr 0x000010, len 4, out_ready=1 -> bytes 0x10,0x11,0x12,0x13 in order; exactly 32+32 SCK rises; flash_csb high afterwards.
REQ-023 Backpressure: addr 0x000100, len 8, out_ready toggling 3 cycles low/1 high -> bytes 0x00..0x07, no loss or duplication; flash_clk low throughout every STALL.
REQ-024 Length zero: addr 0x000000, len 0 -> exactly 256 bytes 0x00..0xFF, then IDLE.
REQ-025 Reset abort: resetb pulsed low during the 2nd DATA byte of a len-8 read -> same cycle flash_csb=1, out_valid=0; a subsequent read of addr 0x000020, len 2 returns 0x20,0x21.
REQ-026 Fast-read build (SPI_FLASH_FAST_READ_EN), CLK_DIV=1: addr 0x000040, len 2 -> opcode 0x0B and 8 dummy SCKs seen on the bus; bytes 0x40,0x41; CSB high for >=CSB_IDLE cycles before req_ready=1.
